// File: rtl/prbs_checker.sv
// Self-synchronising checker for the XNOR-feedback LFSR generator: hunts, syncs, locks, counts errors.
// Optional Bit_Err_Cnt output is enabled by defining PRBS_CHK_BITCNT_EN.
//
//   state     | meaning
//   ST_HUNT   | waiting for a usable (not all-ones) seed word
//   ST_SYNC   | predicting from received data, counting consecutive correct predictions
//   ST_LOCKED | free-running prediction, counting errors and consecutive misses
module prbs_checker #(
  parameter int NUM_BITS = 32,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                E,
  input  logic [NUM_BITS-1:0] Rx_Data,
  input  logic                Clear,
  output logic                Locked,
  output logic                Err,
  output logic [CNT_BITS-1:0] Err_Cnt,
  output logic                Stuck
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [CNT_BITS-1:0] Bit_Err_Cnt
`endif
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  function automatic logic [63:0] bitpos(input int k);
    return (k > 0) ? (64'd1 << (k - 1)) : 64'd0;
  endfunction

  function automatic logic [63:0] taps(input int a, input int b, input int c, input int d);
    return bitpos(a) | bitpos(b) | bitpos(c) | bitpos(d);
  endfunction

  // Tap k refers to word bit k-1; unused slots are 0.
  function automatic logic [63:0] tap_mask(input int n);
    logic [63:0] m;
    m = '0;
    case (n)
      3:  m = taps(3, 2, 0, 0);
      4:  m = taps(4, 3, 0, 0);
      5:  m = taps(5, 3, 0, 0);
      6:  m = taps(6, 5, 0, 0);
      7:  m = taps(7, 6, 0, 0);
      8:  m = taps(8, 6, 5, 4);
      9:  m = taps(9, 5, 0, 0);
      10: m = taps(10, 7, 0, 0);
      11: m = taps(11, 9, 0, 0);
      12: m = taps(12, 6, 4, 1);
      13: m = taps(13, 4, 3, 1);
      14: m = taps(14, 5, 3, 1);
      15: m = taps(15, 14, 0, 0);
      16: m = taps(16, 15, 13, 4);
      17: m = taps(17, 14, 0, 0);
      18: m = taps(18, 11, 0, 0);
      19: m = taps(19, 6, 2, 1);
      20: m = taps(20, 17, 0, 0);
      21: m = taps(21, 19, 0, 0);
      22: m = taps(22, 21, 0, 0);
      23: m = taps(23, 18, 0, 0);
      24: m = taps(24, 23, 22, 17);
      25: m = taps(25, 22, 0, 0);
      26: m = taps(26, 6, 2, 1);
      27: m = taps(27, 5, 2, 1);
      28: m = taps(28, 25, 0, 0);
      29: m = taps(29, 27, 0, 0);
      30: m = taps(30, 6, 4, 1);
      31: m = taps(31, 28, 0, 0);
      32: m = taps(32, 22, 2, 1);
      default: m = taps(64, 63, 61, 60);
    endcase
    return m;
  endfunction

  localparam logic [63:0]         TAP_MASK64 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK   = TAP_MASK64[NUM_BITS-1:0];

  function automatic logic [NUM_BITS-1:0] nx(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], ~^(w & TAP_MASK)};
  endfunction

  logic [1:0]          state;
  logic [NUM_BITS-1:0] expected;
  logic [MW-1:0]       match_cnt;
  logic [LW-1:0]       miss_cnt;
  logic                rx_ones;
  logic                hit;
  logic                cnt_inc;

  assign rx_ones = &Rx_Data;
  assign hit     = (Rx_Data == expected);
  assign cnt_inc = (state == ST_LOCKED) && !hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      Locked    <= 1'b0;
      Err       <= 1'b0;
      Stuck     <= 1'b0;
    end else begin
      Err <= E & cnt_inc;
      if (E) begin
        Stuck <= rx_ones;
        case (state)
          ST_HUNT: begin
            if (!rx_ones) begin
              expected  <= nx(Rx_Data);
              match_cnt <= '0;
              state     <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            expected <= nx(Rx_Data);
            if (hit) begin
              if (match_cnt == LOCK_LAST) begin
                state    <= ST_LOCKED;
                Locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Prediction free-runs so a corrupted word cannot derail the sequence.
            expected <= nx(expected);
            if (hit) begin
              miss_cnt <= '0;
            end else if (miss_cnt == LOSS_LAST) begin
              state  <= ST_HUNT;
              Locked <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Err_Cnt <= '0;
    end else if (E) begin
      if (Clear)
        Err_Cnt <= '0;
      else if (cnt_inc && !(&Err_Cnt))
        Err_Cnt <= Err_Cnt + CNT_BITS'(1);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  localparam int SW = CNT_BITS + 8;

  function automatic logic [6:0] popcount(input logic [NUM_BITS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < NUM_BITS; i++)
      n = n + 7'(v[i]);
    return n;
  endfunction

  logic [SW-1:0] bit_sum;
  assign bit_sum = SW'(Bit_Err_Cnt) + SW'(popcount(Rx_Data ^ expected));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Bit_Err_Cnt <= '0;
    end else if (E) begin
      if (Clear)
        Bit_Err_Cnt <= '0;
      else if (state == ST_LOCKED)
        Bit_Err_Cnt <= (bit_sum > SW'({CNT_BITS{1'b1}})) ? '1 : bit_sum[CNT_BITS-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: two 8-bit instances (lock/loss behaviour and counter saturation).
// Bit_Err_Cnt is checked when PRBS_CHK_BITCNT_EN is defined.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_a, e_b;
  logic [7:0] rx;
  logic       clr;

  logic        locked_a, err_a, stuck_a;
  logic [15:0] cnt_a;
  logic        locked_b, err_b, stuck_b;
  logic [3:0]  cnt_b;
`ifdef PRBS_CHK_BITCNT_EN
  logic [15:0] bits_a;
  logic [3:0]  bits_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prbs_checker #(.NUM_BITS(8), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_BITS(16)) dut_a (
    .CLK(clk), .nRST(rst_n), .E(e_a), .Rx_Data(rx), .Clear(clr),
    .Locked(locked_a), .Err(err_a), .Err_Cnt(cnt_a), .Stuck(stuck_a)
`ifdef PRBS_CHK_BITCNT_EN
    , .Bit_Err_Cnt(bits_a)
`endif
  );

  prbs_checker #(.NUM_BITS(8), .LOCK_CNT(1), .LOSS_CNT(32), .CNT_BITS(4)) dut_b (
    .CLK(clk), .nRST(rst_n), .E(e_b), .Rx_Data(rx), .Clear(clr),
    .Locked(locked_b), .Err(err_b), .Err_Cnt(cnt_b), .Stuck(stuck_b)
`ifdef PRBS_CHK_BITCNT_EN
    , .Bit_Err_Cnt(bits_b)
`endif
  );

  typedef struct {
    bit          sel_b;
    string       name;
    logic [18:0] exp;
    bit          chk_bits;
    logic [15:0] exp_bits;
  } item_t;

  item_t      sb[$];
  logic [7:0] s [0:63];

  // Independent 8-bit reference: feedback = XNOR of bits 7,5,4,3.
  function automatic logic [7:0] nx8(input logic [7:0] w);
    return {w[6:0], ~(w[7] ^ w[5] ^ w[4] ^ w[3])};
  endfunction

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (locked,err,cnt,stuck)", nm, act, req);
    end
  endtask

  task automatic feed(input bit sel_b, input bit en, input logic [7:0] d, input bit c,
                      input string nm, input logic lk, input logic er, input int cnt,
                      input logic st, input int bits);
    item_t it;
    e_a = en && !sel_b;
    e_b = en && sel_b;
    rx  = d;
    clr = c;
    @(posedge clk);
    it.sel_b    = sel_b;
    it.name     = nm;
    it.exp      = {lk, er, 16'(cnt), st};
    it.chk_bits = (bits >= 0);
    it.exp_bits = 16'(bits);
    sb.push_back(it);
    #1;
  endtask

  item_t       mit;
  logic [18:0] mact;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mit  = sb.pop_front();
      mact = mit.sel_b ? {locked_b, err_b, 12'd0, cnt_b, stuck_b}
                       : {locked_a, err_a, cnt_a, stuck_a};
      check(mit.name, mact, mit.exp);
`ifdef PRBS_CHK_BITCNT_EN
      if (mit.chk_bits)
        check({mit.name, "_bits"}, mit.sel_b ? {15'd0, bits_b} : {3'd0, bits_a},
              {3'd0, mit.exp_bits});
`endif
    end
  end

  logic [7:0] hand [0:5];
  logic [7:0] d;

  initial begin
    rst_n = 1'b0; e_a = 1'b0; e_b = 1'b0; rx = '0; clr = 1'b0;
    s[0] = 8'h00;
    for (int i = 1; i < 64; i++) s[i] = nx8(s[i-1]);
    hand[0] = 8'h00; hand[1] = 8'h01; hand[2] = 8'h03;
    hand[3] = 8'h07; hand[4] = 8'h0F; hand[5] = 8'h1E;

    #12;
    check("reset_a", {locked_a, err_a, cnt_a, stuck_a}, 19'd0);
    check("reset_b", {locked_b, err_b, 12'd0, cnt_b, stuck_b}, 19'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Acquisition: HUNT on 0x00, then four correct predictions lock.
    for (int i = 0; i < 6; i++)
      feed(0, 1, hand[i], 0, "acquire", (i >= 4), 0, 0, 0, -1);
    for (int i = 6; i < 10; i++)
      feed(0, 1, s[i], 0, "locked_run", 1, 0, 0, &s[i], -1);

    feed(0, 1, s[10] ^ 8'h01, 0, "single_err", 1, 1, 1, &(s[10] ^ 8'h01), -1);
    for (int i = 11; i < 14; i++)
      feed(0, 1, s[i], 0, "after_err", 1, 0, 1, &s[i], -1);

    // Four consecutive misses drop lock on the fourth, which is still counted.
    for (int k = 0; k < 4; k++) begin
      d = s[14+k] ^ 8'hA5;
      feed(0, 1, d, 0, "loss", (k < 3), 1, 2 + k, &d, -1);
    end
    for (int i = 18; i < 23; i++)
      feed(0, 1, s[i], 0, "relock", (i >= 22), 0, 5, &s[i], -1);

    feed(0, 1, s[23] ^ 8'h01, 0, "pre_hold_err", 1, 1, 6, &(s[23] ^ 8'h01), -1);
    for (int k = 0; k < 5; k++)
      feed(0, 0, 8'hFF, 1, "hold_e0", 1, 0, 6, 0, -1);
    feed(0, 1, s[24], 0, "resume", 1, 0, 6, &s[24], -1);

    for (int k = 0; k < 4; k++)
      feed(0, 1, 8'hFF, 0, "ones_locked", (k < 3), 1, 7 + k, 1, -1);
    feed(0, 1, 8'hFF, 0, "ones_hunt", 0, 0, 10, 1, -1);
    feed(0, 1, 8'hFF, 0, "ones_hunt2", 0, 0, 10, 1, -1);
    feed(0, 1, s[30], 0, "hunt_exit", 0, 0, 10, &s[30], -1);
    feed(0, 1, s[31], 1, "clear_sync", 0, 0, 0, &s[31], -1);
    for (int i = 32; i < 35; i++)
      feed(0, 1, s[i], 0, "relock2", (i >= 34), 0, 0, &s[i], -1);
    feed(0, 1, 8'hFF, 0, "pre_rst", 1, 1, 1, 1, -1);
    e_a = 1'b0;

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", {locked_a, err_a, cnt_a, stuck_a}, 19'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // LOCK_CNT=1, CNT_BITS=4: first correct prediction locks; counter saturates at 15.
    feed(1, 1, s[0], 0, "b_hunt", 0, 0, 0, 0, 0);
    feed(1, 1, s[1], 0, "b_lock1", 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      d = s[1+k] ^ ((k == 1) ? 8'h07 : 8'h01);
      feed(1, 1, d, 0, "b_sat", 1, 1, (k < 15) ? k : 15, &d,
           (k + 2 < 15) ? k + 2 : 15);
    end
    feed(1, 1, s[22] ^ 8'h01, 1, "b_clear_win", 1, 1, 0, &(s[22] ^ 8'h01), 0);
    feed(1, 1, s[23], 0, "b_after_clear", 1, 0, 0, &s[23], 0);
    e_b = 1'b0;

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
